survivor_writer: RTL and testbench
==================================

Name: survivor_writer

Overview:
- Write side of the Viterbi survivor memory. Takes the 256 ACS decision bits of each trellis step as 32 bytes, one per beat, and writes them into the 2048x8 survivor RAM.
- RAM word address is {step[5:0], group[4:0]}. Group = state[7:3]; bit index inside the word = state[2:0]. The traceback unit reads with exactly this addressing.
- After each completed step, issues a traceback request carrying the start state and the step index.

Parameters:
TB_DEPTH, 32, steps that must be stored before the first traceback request; legal range 1..63
N_GROUPS, 32, survivor bytes per step (2^(`WD_STATE-3)); fixed, not for override

Ports:
Clock  in  1  single clock; all state changes on posedge
Reset  in  1  asynchronous, active-low reset
SurvValid  in  1  survivor byte offered
SurvData  in  `WD_RAM_DATA (8)  decisions of states {group,3'b000}..{group,3'b111}; bit i = state {group,i}
SurvReady  out  1  byte accepted on a cycle where SurvValid && SurvReady
BestState  in  `WD_STATE (8)  minimum-metric state; sampled only on acceptance of group 31
FrameEnd  in  1  sampled only on acceptance of group 31; marks the last step of the frame
WrEn  out  1  RAM write strobe
WrAddress  out  `WD_RAM_ADDRESS (11)  {Step[5:0], Group[4:0]}
WrData  out  8  byte to write
TbReq  out  1  traceback request, level, held until acknowledged
TbAck  in  1  traceback unit accepts request
TbInitState  out  8  start state for traceback
TbStep  out  `WD_FSM (6)  step index traceback starts from
TbLast  out  1  request is the frame-final (zero-tail) traceback

Behaviour:
- Reset (asynchronous, any time including mid-step or with TbReq pending):
  - Outputs: WrEn=0, WrAddress=0, WrData=0, TbReq=0, TbInitState=0, TbStep=0, TbLast=0, SurvReady=1.
  - Internal: Group=0, Step=0, Fill=0. Any pending request is discarded.
- Write path, latency 1:
  - On an accepted beat, the next cycle shows WrEn=1, WrAddress={Step,Group}, WrData=SurvData.
  - Group then increments mod 32.
  - WrEn=0 in any cycle with no accepted beat.
- Step completion (accepted beat with Group=31):
  - Step increments mod 64; wrap 63->0 is normal circular operation.
  - Fill saturates at TB_DEPTH.
- Request generation, registered with the completion edge:
  - Trigger: Fill reaches TB_DEPTH after that step is counted, or FrameEnd=1.
  - TbReq rises 1 cycle after the group-31 beat.
  - TbStep = index of the step just written.
  - TbInitState = BestState, or 0 when FrameEnd=1.
  - TbLast = FrameEnd.
  - TbInitState, TbStep and TbLast are stable while TbReq=1.
- Handshake:
  - TbReq && TbAck at a posedge retires the request; TbReq=0 the next cycle.
  - TbAck while TbReq=0 is ignored.
- Back-pressure: SurvReady = !(TbReq && Group==31).
  - Writing groups 0..30 of the next step overlaps the outstanding traceback.
  - Completing that step waits for the ack.
  - This guarantees at most one outstanding request.
  - With TB_DEPTH<=63, no stored step of the active window is overwritten.
- Simultaneous events:
  - Ack and a new group-31 beat cannot coincide, because SurvReady=0.
  - Ack on the same edge as a group-0..30 beat: both take effect.
- Frame end: when a TbLast request is acknowledged, Step, Group and Fill clear to 0 on that edge and the next frame starts at address 0.
- FSM, 3 states:
  - FILL (Fill<TB_DEPTH, no request) -> REQ on completion that meets the trigger.
  - RUN (Fill=TB_DEPTH, no request) -> REQ on every completion.
  - REQ: on ack -> RUN, or -> FILL if TbLast.
  - Reset -> FILL.

Decomposition:
- Shared params.v: `WD_STATE, `WD_RAM_DATA, `WD_RAM_ADDRESS, `WD_FSM.
- Add to params.v: `TB_DEPTH default and `N_GROUPS = 1<<(`WD_STATE-3).
- One natural sub-module: surv_addr_gen, holding the Group/Step/Fill counters with wrap and clear. The request FSM and output registers stay in survivor_writer.

Test Plan:
- Reset mid-step: assert Reset after 10 beats with TbReq=1 -> all outputs 0 and SurvReady=1 immediately; first beat after release writes WrAddress=0.
- Address mapping: 64 steps x 32 beats, SurvData=Group^Step -> WrAddress sequence 0..2047, each write 1 cycle after its accept; Step wraps 63->0 on the next beat.
- Fill threshold (TB_DEPTH=32, TbAck tied 1): no TbReq during steps 0..30; first TbReq after step 31 with TbStep=31, TbInitState=BestState (0xA5 driven); one request per step afterwards.
- Back-pressure: hold TbAck=0 -> groups 0..30 of the next step accepted, SurvReady=0 at group 31; TbAck pulse -> SurvReady=1 the next cycle, no byte lost or duplicated.
- Frame end at step 5 (Fill<TB_DEPTH), FrameEnd=1, BestState=0x3C -> TbReq with TbInitState=0, TbLast=1, TbStep=5; after ack, next write at WrAddress=0.
- Spurious TbAck with TbReq=0, and TbAck on the same edge as a group-7 beat -> no state corruption; write and retire both happen.

Source files
------------

// File: rtl/survivor_writer_pkg.sv
// Shared widths, counter limits and FSM encoding for the survivor-memory write side.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package survivor_writer_pkg;

    localparam int WD_STATE         = 8;                    // trellis state width
    localparam int WD_RAM_DATA      = 8;                    // survivor RAM word width
    localparam int WD_GROUP         = WD_STATE - 3;         // byte-group index width
    localparam int WD_FSM           = 6;                    // step index width
    localparam int WD_RAM_ADDRESS   = WD_FSM + WD_GROUP;    // {step, group}
    localparam int N_GROUPS         = 1 << WD_GROUP;        // survivor bytes per step
    localparam int TB_DEPTH_DEFAULT = 32;                   // steps stored before first traceback

    localparam logic [WD_GROUP-1:0] LAST_GROUP = WD_GROUP'(N_GROUPS - 1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,     // window not yet full, no request outstanding
        ST_RUN  = 2'd1,     // window full, no request outstanding
        ST_REQ  = 2'd2      // traceback request outstanding
    } tb_state_e;

endpackage

// File: rtl/surv_addr_gen.sv
// Group/Step/Fill counters for the survivor RAM write address; clr returns all to 0.
// Latency: counters update on the edge of the accepted beat (adv) or of clr.
// Backpressure: none here; the caller only asserts adv for accepted beats.
// Ports: clk/rst_n; adv = accepted beat; clr = frame restart (wins over adv);
//        group_q/step_q/fill_q = current counters; last_group = group_q is the final group.
module surv_addr_gen
    import survivor_writer_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adv,
    input  logic                clr,
    output logic [WD_GROUP-1:0] group_q,
    output logic [WD_FSM-1:0]   step_q,
    output logic [WD_FSM-1:0]   fill_q,
    output logic                last_group
);

    localparam logic [WD_FSM-1:0] FILL_MAX = WD_FSM'(TB_DEPTH);

    logic [WD_GROUP-1:0] group_d;
    logic [WD_FSM-1:0]   step_d;
    logic [WD_FSM-1:0]   fill_d;

    assign last_group = (group_q == LAST_GROUP);

    always_comb begin
        group_d = group_q;
        step_d  = step_q;
        fill_d  = fill_q;
        if (clr) begin
            group_d = '0;
            step_d  = '0;
            fill_d  = '0;
        end else if (adv) begin
            group_d = group_q + WD_GROUP'(1);
            if (last_group) begin
                // Step wraps 63->0 as normal circular use of the RAM.
                step_d = step_q + WD_FSM'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + WD_FSM'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            group_q <= '0;
            step_q  <= '0;
            fill_q  <= '0;
        end else begin
            group_q <= group_d;
            step_q  <= step_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/survivor_writer.sv
// Writes 32 survivor bytes per trellis step into the 2048x8 RAM and raises a traceback request per completed step.
// Latency: RAM write 1 cycle after accept; TbReq 1 cycle after the group-31 beat.
// Backpressure: SurvReady drops only for the group-31 beat while a request is outstanding.
// Ports: SurvValid/SurvData/SurvReady = byte input; BestState/FrameEnd sampled with group 31;
//        WrEn/WrAddress/WrData = RAM write port; TbReq/TbAck/TbInitState/TbStep/TbLast = traceback request.
module survivor_writer
    import survivor_writer_pkg::*;
#(
    parameter int TB_DEPTH = TB_DEPTH_DEFAULT
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      SurvValid,
    input  logic [WD_RAM_DATA-1:0]    SurvData,
    output logic                      SurvReady,
    input  logic [WD_STATE-1:0]       BestState,
    input  logic                      FrameEnd,
    output logic                      WrEn,
    output logic [WD_RAM_ADDRESS-1:0] WrAddress,
    output logic [WD_RAM_DATA-1:0]    WrData,
    output logic                      TbReq,
    input  logic                      TbAck,
    output logic [WD_STATE-1:0]       TbInitState,
    output logic [WD_FSM-1:0]         TbStep,
    output logic                      TbLast
);

    // Fill value before the step whose completion fills the window.
    localparam logic [WD_FSM-1:0] FILL_TRIG = WD_FSM'(TB_DEPTH - 1);

    logic [WD_GROUP-1:0] group_q;
    logic [WD_FSM-1:0]   step_q;
    logic [WD_FSM-1:0]   fill_q;
    logic                last_group;
    logic                accept;
    logic                step_done;
    logic                frame_clr;

    tb_state_e                 state_q, state_d;
    logic                      wr_en_q, wr_en_d;
    logic [WD_RAM_ADDRESS-1:0] wr_addr_q, wr_addr_d;
    logic [WD_RAM_DATA-1:0]    wr_data_q, wr_data_d;
    logic                      tb_req_q, tb_req_d;
    logic [WD_STATE-1:0]       tb_init_q, tb_init_d;
    logic [WD_FSM-1:0]         tb_step_q, tb_step_d;
    logic                      tb_last_q, tb_last_d;

    // Holding off only the step-completing beat keeps at most one request outstanding
    // while the next step's groups 0..30 overlap the traceback.
    assign SurvReady = !(tb_req_q && last_group);
    assign accept    = SurvValid && SurvReady;
    assign step_done = accept && last_group;
    // Retiring a frame-final request restarts the frame at address 0.
    assign frame_clr = tb_req_q && TbAck && tb_last_q;

    surv_addr_gen #(
        .TB_DEPTH (TB_DEPTH)
    ) u_addr_gen (
        .clk        (Clock),
        .rst_n      (Reset),
        .adv        (accept),
        .clr        (frame_clr),
        .group_q    (group_q),
        .step_q     (step_q),
        .fill_q     (fill_q),
        .last_group (last_group)
    );

    always_comb begin
        state_d   = state_q;
        wr_en_d   = accept;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tb_req_d  = tb_req_q;
        tb_init_d = tb_init_q;
        tb_step_d = tb_step_q;
        tb_last_d = tb_last_q;

        if (accept) begin
            wr_addr_d = {step_q, group_q};
            wr_data_d = SurvData;
        end

        case (state_q)
            ST_FILL, ST_RUN: begin
                if (step_done && (state_q == ST_RUN || FrameEnd || fill_q == FILL_TRIG)) begin
                    state_d   = ST_REQ;
                    tb_req_d  = 1'b1;
                    tb_step_d = step_q;
                    // Zero-tail frames always end in state 0.
                    tb_init_d = FrameEnd ? '0 : BestState;
                    tb_last_d = FrameEnd;
                end
            end
            ST_REQ: begin
                if (TbAck) begin
                    tb_req_d = 1'b0;
                    state_d  = tb_last_q ? ST_FILL : ST_RUN;
                end
            end
            default: begin
                state_d  = ST_FILL;
                tb_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_FILL;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tb_req_q  <= 1'b0;
            tb_init_q <= '0;
            tb_step_q <= '0;
            tb_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            tb_req_q  <= tb_req_d;
            tb_init_q <= tb_init_d;
            tb_step_q <= tb_step_d;
            tb_last_q <= tb_last_d;
        end
    end

    assign WrEn        = wr_en_q;
    assign WrAddress   = wr_addr_q;
    assign WrData      = wr_data_q;
    assign TbReq       = tb_req_q;
    assign TbInitState = tb_init_q;
    assign TbStep      = tb_step_q;
    assign TbLast      = tb_last_q;

endmodule

// File: tb/tb_survivor_writer.sv
// Directed bench for survivor_writer: reset, address mapping, fill threshold,
// back-pressure, ack overlap, mid-step reset and frame end.
module tb_survivor_writer;

    logic        Clock;
    logic        Reset;
    logic        SurvValid;
    logic [7:0]  SurvData;
    logic        SurvReady;
    logic [7:0]  BestState;
    logic        FrameEnd;
    logic        WrEn;
    logic [10:0] WrAddress;
    logic [7:0]  WrData;
    logic        TbReq;
    logic        TbAck;
    logic [7:0]  TbInitState;
    logic [5:0]  TbStep;
    logic        TbLast;

    int checks = 0;
    int errors = 0;

    // Expected write position
    logic [5:0] m_step;
    logic [4:0] m_group;

    survivor_writer #(.TB_DEPTH(32)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .SurvValid   (SurvValid),
        .SurvData    (SurvData),
        .SurvReady   (SurvReady),
        .BestState   (BestState),
        .FrameEnd    (FrameEnd),
        .WrEn        (WrEn),
        .WrAddress   (WrAddress),
        .WrData      (WrData),
        .TbReq       (TbReq),
        .TbAck       (TbAck),
        .TbInitState (TbInitState),
        .TbStep      (TbStep),
        .TbLast      (TbLast)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One accepted beat at the current model position; checks the write one cycle later.
    task automatic beat(input logic [7:0] d);
        int n;
        n = 0;
        SurvValid = 1'b1;
        SurvData  = d;
        while (!SurvReady && n < 50) begin
            tick();
            n++;
        end
        chk("ready_before_beat", {31'd0, SurvReady}, 32'd1);
        tick();
        SurvValid = 1'b0;
        chk("wr_en", {31'd0, WrEn}, 32'd1);
        chk("wr_addr", {21'd0, WrAddress}, {21'd0, m_step, m_group});
        chk("wr_data", {24'd0, WrData}, {24'd0, d});
        if (m_group == 5'd31) m_step = m_step + 6'd1;
        m_group = m_group + 5'd1;
    endtask

    task automatic chk_req(input logic [5:0] st, input logic [7:0] init, input logic last);
        chk("tb_req", {31'd0, TbReq}, 32'd1);
        chk("tb_step", {26'd0, TbStep}, {26'd0, st});
        chk("tb_init", {24'd0, TbInitState}, {24'd0, init});
        chk("tb_last", {31'd0, TbLast}, {31'd0, last});
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wr_en", {31'd0, WrEn}, 32'd0);
        chk("rst_wr_addr", {21'd0, WrAddress}, 32'd0);
        chk("rst_wr_data", {24'd0, WrData}, 32'd0);
        chk("rst_tb_req", {31'd0, TbReq}, 32'd0);
        chk("rst_tb_init", {24'd0, TbInitState}, 32'd0);
        chk("rst_tb_step", {26'd0, TbStep}, 32'd0);
        chk("rst_tb_last", {31'd0, TbLast}, 32'd0);
        chk("rst_ready", {31'd0, SurvReady}, 32'd1);
    endtask

    initial begin
        Reset     = 1'b0;
        SurvValid = 1'b0;
        SurvData  = 8'h00;
        BestState = 8'h00;
        FrameEnd  = 1'b0;
        TbAck     = 1'b0;
        m_step    = 6'd0;
        m_group   = 5'd0;

        // Reset state
        repeat (3) tick();
        chk_reset_outputs();
        Reset = 1'b1;
        tick();

        // Address mapping over 64 steps with TbAck tied high; fill threshold at step 31
        TbAck     = 1'b1;
        BestState = 8'hA5;
        for (int s = 0; s < 64; s++) begin
            for (int g = 0; g < 32; g++) begin
                beat(8'(g ^ s));
                if (g == 0 && s >= 32) chk("req_retired", {31'd0, TbReq}, 32'd0);
                if (g == 31) begin
                    if (s >= 31) chk_req(6'(s), 8'hA5, 1'b0);
                    else chk("no_req_filling", {31'd0, TbReq}, 32'd0);
                end
            end
        end
        // Step wrapped 63->0: next beat lands at address 0
        beat(8'h77);
        chk("wrap_req_retired", {31'd0, TbReq}, 32'd0);

        // Back-pressure: finish step 0 with TbAck low, overlap groups 0..30 of step 1
        TbAck = 1'b0;
        for (int g = 1; g < 32; g++) beat(8'(8'h40 + g));
        chk_req(6'd0, 8'hA5, 1'b0);
        for (int g = 0; g < 31; g++) beat(8'(8'h80 + g));
        chk("req_held_overlap", {31'd0, TbReq}, 32'd1);
        SurvValid = 1'b1;
        SurvData  = 8'hEE;
        chk("bp_ready_low", {31'd0, SurvReady}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_no_write", {31'd0, WrEn}, 32'd0);
            chk("bp_ready_held", {31'd0, SurvReady}, 32'd0);
        end
        TbAck = 1'b1;
        tick();
        TbAck = 1'b0;
        chk("bp_ack_retired", {31'd0, TbReq}, 32'd0);
        chk("bp_ready_back", {31'd0, SurvReady}, 32'd1);
        chk("bp_still_no_write", {31'd0, WrEn}, 32'd0);
        beat(8'hEE);
        chk_req(6'd1, 8'hA5, 1'b0);
        tick();
        chk("bp_no_dup_write", {31'd0, WrEn}, 32'd0);

        // Ack on the same edge as a group-7 beat: write and retire both happen
        for (int g = 0; g < 7; g++) beat(8'(8'hC0 + g));
        chk("req_pending_g7", {31'd0, TbReq}, 32'd1);
        TbAck = 1'b1;
        beat(8'hC7);
        TbAck = 1'b0;
        chk("ack_with_beat_retired", {31'd0, TbReq}, 32'd0);
        for (int g = 8; g < 32; g++) beat(8'(8'hC0 + g));
        chk_req(6'd2, 8'hA5, 1'b0);

        // Reset mid-step with TbReq pending
        for (int g = 0; g < 10; g++) beat(8'(8'h10 + g));
        chk("req_before_reset", {31'd0, TbReq}, 32'd1);
        Reset = 1'b0;
        #1;
        chk_reset_outputs();
        m_step  = 6'd0;
        m_group = 5'd0;
        tick();
        Reset = 1'b1;
        tick();

        // Spurious ack with no request outstanding
        TbAck = 1'b1;
        tick();
        tick();
        TbAck = 1'b0;
        chk("spurious_ack_req", {31'd0, TbReq}, 32'd0);
        chk("spurious_ack_ready", {31'd0, SurvReady}, 32'd1);
        chk("spurious_ack_wr", {31'd0, WrEn}, 32'd0);

        // Frame end at step 5 before the window fills; first beat writes address 0
        for (int s = 0; s < 6; s++) begin
            for (int g = 0; g < 32; g++) begin
                FrameEnd  = ((s == 2 && g == 7) || (s == 5 && g == 31));
                BestState = (s == 5 && g == 31) ? 8'h3C : 8'h55;
                beat(8'(8'h20 + s + g));
                FrameEnd  = 1'b0;
                if (g == 31 && s < 5) chk("frame_no_req", {31'd0, TbReq}, 32'd0);
            end
        end
        chk_req(6'd5, 8'h00, 1'b1);
        BestState = 8'hFF;
        tick();
        tick();
        chk_req(6'd5, 8'h00, 1'b1);
        TbAck = 1'b1;
        tick();
        TbAck = 1'b0;
        chk("frame_ack_retired", {31'd0, TbReq}, 32'd0);
        m_step  = 6'd0;
        m_group = 5'd0;
        beat(8'h99);
        tick();
        chk("frame_idle", {31'd0, WrEn}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
